// File: rtl/toggle_cov_pkg.sv
// Shared types for the toggle coverage event path: cover index width/type and
// a helper sizing the bit-position field of the per-bit priority encoder.
package toggle_cov_pkg;

    localparam int COV_IDX_W = 64;

    typedef logic [COV_IDX_W-1:0] cov_idx_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_pick_lowest.sv
// Combinational priority encoder: reports whether any request bit is set and
// the position of the lowest set bit.
module toggle_pick_lowest
    import toggle_cov_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/toggle_event_source.sv
// Per-bit toggle tracker emitting one cover event per fully toggled bit.
// Optional macro TOGGLE_REARM_EN adds the rearm input that restarts tracking.
module toggle_event_source
    import toggle_cov_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int unsigned COVER_BASE = 0
) (
    input  logic             gbl_clk,
    input  logic             reset,
`ifdef TOGGLE_REARM_EN
    input  logic             rearm,
`endif
    input  logic             sample_en,
    input  logic [WIDTH-1:0] sig,
    output logic             cov_valid,
    input  logic             cov_ready,
    output cov_idx_t         cov_index,
    output logic             all_done
);

    localparam int IDX_W = idx_width(WIDTH);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             cov_valid_q, cov_valid_d;
    cov_idx_t         cov_index_q, cov_index_d;
    logic             all_done_q, all_done_d;

    logic             sample_take;
    logic             rearm_now;
    logic [WIDTH-1:0] done_q;
    logic [WIDTH-1:0] completed;
    logic             load;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

`ifdef TOGGLE_REARM_EN
    assign rearm_now = rearm;
`else
    assign rearm_now = 1'b0;
`endif

    // A sample coinciding with rearm is discarded entirely.
    assign sample_take = sample_en & ~rearm_now;
    assign done_q      = rise_q & fall_q;

    always_comb begin
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        rise_d    = rise_q;
        fall_d    = fall_q;
        if (sample_take) begin
            if (prev_ok_q) begin
                rise_d = rise_q | (~prev_q & sig);
                fall_d = fall_q | (prev_q & ~sig);
            end
            prev_d    = sig;
            prev_ok_d = 1'b1;
        end
        if (rearm_now) begin
            rise_d = '0;
            fall_d = '0;
        end
    end

    assign completed  = (rise_d & fall_d) & ~done_q;
    assign all_done_d = rearm_now ? 1'b0 : &done_q;

    toggle_pick_lowest #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (pending_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // cov_valid/cov_ready: an event transfers on an edge where both are high;
    // while valid is high and ready low the index holds; ready alone is ignored.
    assign load = ~cov_valid_q | cov_ready;

    always_comb begin
        pending_d   = pending_q;
        cov_valid_d = cov_valid_q;
        cov_index_d = cov_index_q;
        if (load) begin
            cov_valid_d = pick_found;
            if (pick_found) begin
                cov_index_d = cov_idx_t'(COVER_BASE) + cov_idx_t'(pick_idx);
                for (int i = 0; i < WIDTH; i++) begin
                    if (pick_idx == IDX_W'(i)) begin
                        pending_d[i] = 1'b0;
                    end
                end
            end
        end
        // New completions are merged after the clear so none can be lost.
        pending_d = pending_d | completed;
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            rise_q      <= '0;
            fall_q      <= '0;
            pending_q   <= '0;
            cov_valid_q <= 1'b0;
            cov_index_q <= '0;
            all_done_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pending_q   <= pending_d;
            cov_valid_q <= cov_valid_d;
            cov_index_q <= cov_index_d;
            all_done_q  <= all_done_d;
        end
    end

    assign cov_valid = cov_valid_q;
    assign cov_index = cov_index_q;
    assign all_done  = all_done_q;

endmodule

// File: tb/tb_toggle_event_source.sv
// Directed and randomized checks of toggle_event_source (WIDTH=4, COVER_BASE=100)
// against a per-bit toggle bookkeeping model; TOGGLE_REARM_EN enables rearm steps.
module tb_toggle_event_source;

    logic        gbl_clk;
    logic        reset;
    logic        rearm;
    logic        sample_en;
    logic [3:0]  sig;
    logic        cov_valid;
    logic        cov_ready;
    logic [63:0] cov_index;
    logic        all_done;

    int n_checks;
    int n_fail;
    bit mon_en;

    // Reference model: last sampled value, seen rise/fall per bit, reported
    // flag per arming, and the set of events owed to the consumer.
    bit         m_have;
    logic [3:0] m_last;
    logic [3:0] m_r;
    logic [3:0] m_f;
    logic [3:0] m_rep;
    logic [3:0] m_owed;
    logic       ad_exp;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [3:0]  rs;
    logic        hs_ok;
    int unsigned hs_k;

    toggle_event_source #(
        .WIDTH      (4),
        .COVER_BASE (100)
    ) dut (
        .gbl_clk   (gbl_clk),
        .reset     (reset),
`ifdef TOGGLE_REARM_EN
        .rearm     (rearm),
`endif
        .sample_en (sample_en),
        .sig       (sig),
        .cov_valid (cov_valid),
        .cov_ready (cov_ready),
        .cov_index (cov_index),
        .all_done  (all_done)
    );

    initial begin
        gbl_clk = 1'b0;
        forever #5 gbl_clk = ~gbl_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, let one active edge consume them, return #1 after it.
    task automatic step(input logic se, input logic [3:0] s, input logic rdy);
        sample_en = se;
        sig       = s;
        cov_ready = rdy;
        @(negedge gbl_clk);
        @(posedge gbl_clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
    endtask

    task automatic cmp_got(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_order"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Monitor: inputs are stable at the falling edge, so it sees what the
    // coming rising edge will consume.
    always @(negedge gbl_clk) begin
        if (mon_en) begin
            chk("all_done", {63'd0, all_done}, {63'd0, ad_exp});
            if (reset && cov_valid && cov_ready) begin
                hs_ok = 1'b0;
                if (cov_index >= 64'd100 && cov_index <= 64'd103) begin
                    hs_k  = 32'(cov_index - 64'd100);
                    hs_ok = m_owed[hs_k];
                    m_owed[hs_k] = 1'b0;
                end
                chk("hs_owed", {63'd0, hs_ok}, 64'd1);
                got_q.push_back(cov_index);
            end
            ad_exp = &(m_r & m_f);
            if (!reset) begin
                m_have = 1'b0;
                m_last = '0;
                m_r    = '0;
                m_f    = '0;
                m_rep  = '0;
                m_owed = '0;
                ad_exp = 1'b0;
            end else if (rearm) begin
                m_r    = '0;
                m_f    = '0;
                m_rep  = '0;
                ad_exp = 1'b0;
            end else if (sample_en) begin
                if (m_have) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!m_last[i] && sig[i]) m_r[i] = 1'b1;
                        if (m_last[i] && !sig[i]) m_f[i] = 1'b1;
                        if (m_r[i] && m_f[i] && !m_rep[i]) begin
                            m_rep[i]  = 1'b1;
                            m_owed[i] = 1'b1;
                        end
                    end
                end
                m_last = sig;
                m_have = 1'b1;
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        m_have    = 1'b0;
        m_last    = '0;
        m_r       = '0;
        m_f       = '0;
        m_rep     = '0;
        m_owed    = '0;
        ad_exp    = 1'b0;
        reset     = 1'b0;
        rearm     = 1'b0;
        sample_en = 1'b0;
        sig       = '0;
        cov_ready = 1'b0;
        rs        = '0;

        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        chk("rst_valid", {63'd0, cov_valid}, 64'd0);
        chk("rst_index", cov_index, 64'd0);
        chk("rst_all_done", {63'd0, all_done}, 64'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Single bit: event two edges after the 1->0 sample
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        chk("single_early", {63'd0, cov_valid}, 64'd0);
        step(1'b0, 4'b0000, 1'b1);
        chk("single_valid", {63'd0, cov_valid}, 64'd1);
        chk("single_index", cov_index, 64'd100);
        step(1'b0, 4'b0000, 1'b1);
        chk("single_gone", {63'd0, cov_valid}, 64'd0);
        chk("single_all_done", {63'd0, all_done}, 64'd0);
        exp_q = '{64'd100};
        cmp_got("single");

        // Backpressure: bits 1 and 2 complete together
        step(1'b1, 4'b0110, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b0000, 1'b0);
            chk("bp_hold_valid", {63'd0, cov_valid}, 64'd1);
            chk("bp_hold_index", cov_index, 64'd101);
        end
        step(1'b0, 4'b0000, 1'b1);
        chk("bp_next_valid", {63'd0, cov_valid}, 64'd1);
        chk("bp_next_index", cov_index, 64'd102);
        step(1'b0, 4'b0000, 1'b1);
        chk("bp_drained", {63'd0, cov_valid}, 64'd0);
        exp_q = '{64'd101, 64'd102};
        cmp_got("bp");

        // Once only: bit 3 toggled three full times
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'b1000, 1'b1);
            step(1'b1, 4'b0000, 1'b1);
        end
        repeat (3) step(1'b0, 4'b0000, 1'b1);
        exp_q = '{64'd103};
        cmp_got("once");

        // All bits at once, ascending emission, all_done one edge later
        reset_pulse();
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        chk("all_ad_early", {63'd0, all_done}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0000, 1'b1);
            chk("all_valid", {63'd0, cov_valid}, 64'd1);
            chk("all_index", cov_index, 64'(100 + i));
            chk("all_ad", {63'd0, all_done}, 64'd1);
        end
        step(1'b0, 4'b0000, 1'b1);
        chk("all_gone", {63'd0, cov_valid}, 64'd0);
        exp_q = '{64'd100, 64'd101, 64'd102, 64'd103};
        cmp_got("all");

        // First sample and gating produce no edges
        reset_pulse();
        step(1'b0, 4'b1010, 1'b1);
        step(1'b0, 4'b0101, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b1);
        chk("gate_valid", {63'd0, cov_valid}, 64'd0);
        chk("gate_count", 64'(got_q.size()), 64'd0);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        repeat (6) step(1'b0, 4'b1111, 1'b1);
        exp_q = '{64'd100, 64'd101, 64'd102, 64'd103};
        cmp_got("gate");

        // Reset drops a held event without replay
        reset_pulse();
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        chk("rsthold_valid", {63'd0, cov_valid}, 64'd1);
        chk("rsthold_index", cov_index, 64'd102);
        reset = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
        chk("rsthold_cleared", {63'd0, cov_valid}, 64'd0);
        chk("rsthold_idx0", cov_index, 64'd0);
        reset = 1'b1;
        repeat (3) step(1'b0, 4'b0000, 1'b1);
        chk("rsthold_noreplay", {63'd0, cov_valid}, 64'd0);
        chk("rsthold_count", 64'(got_q.size()), 64'd0);

`ifdef TOGGLE_REARM_EN
        // Rearm lets bit 0 report again; a sample with rearm is discarded
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);
        rearm = 1'b1;
        step(1'b1, 4'b0001, 1'b1);
        rearm = 1'b0;
        chk("rearm_ad", {63'd0, all_done}, 64'd0);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);
        exp_q = '{64'd100, 64'd100};
        cmp_got("rearm");
`endif

        // Randomized traffic; the monitor checks every handshake and all_done
        for (int r = 0; r < 5; r++) begin
            reset_pulse();
            rs = 4'($urandom_range(0, 15));
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 2) == 0) rs = rs ^ 4'(1 << $urandom_range(0, 3));
`ifdef TOGGLE_REARM_EN
                rearm = ($urandom_range(0, 24) == 0);
`endif
                step(1'($urandom_range(0, 1)), rs, ($urandom_range(0, 3) != 0));
            end
            rearm = 1'b0;
            repeat (8) step(1'b0, rs, 1'b1);
            chk("rand_owed", 64'(m_owed), 64'd0);
            chk("rand_idle", {63'd0, cov_valid}, 64'd0);
            got_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_event_source.md
# toggle_event_source

Upstream producer for the per-bit toggle cover points in the coverage instrumentation. It samples a WIDTH-bit monitored signal on `gbl_clk`, tracks which bits have completed a full toggle (both 0->1 and 1->0 observed), and emits exactly one cover event per bit. Events are serialized over a valid/ready port carrying the bit's global cover index. Each accepted event drives the `valid` of the matching toggle cover point.

## Interface
- `WIDTH`, default 32: number of monitored bits, range 1..1024.
- `COVER_BASE`, default 0: global cover index of bit 0. Bit i maps to COVER_BASE+i.
- `gbl_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `sample_en`  in  1  `sig` is sampled this cycle.
- `sig`  in  WIDTH  monitored signal.
- `cov_valid`  out  1  event available.
- `cov_ready`  in  1  consumer accepts the event.
- `cov_index`  out  64  global cover index of the event.
- `all_done`  out  1  every bit has completed a toggle.
- `rearm`  in  1  present only with TOGGLE_REARM_EN. Restarts toggle tracking.

## Operation
- State:
  - `prev[WIDTH]`
  - `prev_ok`
  - `rise[WIDTH]`, `fall[WIDTH]`
  - `pending[WIDTH]`
  - output holding register `{cov_valid, cov_index}`
  - `all_done`
- Reset (`reset`==0 at an edge) clears all state. Reset values: `cov_valid`=0, `cov_index`=0, `all_done`=0.
- First `sample_en` cycle after reset: loads `prev`, sets `prev_ok`, detects no edges.
- Later `sample_en` cycles:
  - `rise[i] |= !prev[i] & sig[i]`
  - `fall[i] |= prev[i] & !sig[i]`
  - `prev <= sig`
- `sample_en`=0: nothing updates. Edges are judged against the last sampled value.
- `done[i] = rise[i] & fall[i]`. `pending[i]` is set on the edge where `done[i]` goes 0->1. A bit reports at most once per arming.
- Output stage loads when it is empty or its event is accepted (`cov_valid & cov_ready`):
  - selects the lowest-index set pending bit;
  - clears that pending bit;
  - sets `cov_index` = COVER_BASE+i, zero-extended to 64 bits.
- If nothing is pending at load time, `cov_valid` goes to 0.
- While `cov_valid & !cov_ready`, `cov_valid` and `cov_index` hold stable.
- `all_done` is registered: `&done`.

## Timing
- Latency: toggle completed by the sample at edge N -> pending after edge N -> `cov_valid` after edge N+1 (empty output stage).
- Throughput: one event per cycle under continuous `cov_ready`.
- Simultaneous completions are emitted in ascending index order, one per accepted handshake.
- A bit completing in the same cycle as an accept cannot be selected until the following cycle.
- Reset mid-operation drops the held event and all pending bits. `cov_valid` is 0 on the cycle after the reset edge.
- `cov_ready` may be high while `cov_valid`=0; this has no effect.

## Configuration
- `TOGGLE_REARM_EN` defined:
  - `rearm` port exists.
  - `rearm`=1 at an edge clears `rise`, `fall` and `all_done` only.
  - `prev`, `prev_ok`, `pending` and the output stage are kept.
  - A sample in the same cycle as `rearm` is discarded, i.e. rearm wins.
- `TOGGLE_REARM_EN` undefined: no `rearm` port; each bit reports once per reset.

## Structure
- Package `toggle_cov_pkg`:
  - `COV_IDX_W`=64
  - `typedef logic [COV_IDX_W-1:0] cov_idx_t`
- Sub-module `toggle_pick_lowest`: combinational priority encoder, WIDTH -> {found, index}. Used for output selection.

## Test plan
All scenarios use WIDTH=4 and COVER_BASE=100.
- Single bit: `sig` 0000 -> 0001 -> 0000 with `sample_en`=1 and `cov_ready`=1 -> one `cov_valid` pulse with `cov_index`=100, two edges after the 1->0 sample. `all_done` stays 0.
- Multi-bit backpressure: bits 2 and 1 complete in the same cycle while `cov_ready`=0 for 5 cycles -> `cov_index`=101 held stable. After `cov_ready` rises: 101 is accepted, then 102 on the next cycle.
- Once only: toggle bit 3 three full times -> exactly one event, 103.
- All bits: toggle all 4 bits -> 4 events (100..103). `all_done`=1 one edge after the last completion.
- First sample / gating: `sig` changes while `sample_en`=0, and the first sample after reset is 1111 -> no events. A subsequent 1111->0000->1111 -> events 100..103.
- Reset and rearm: reset asserted while 102 is held -> `cov_valid`=0 next cycle, no replay. With TOGGLE_REARM_EN, `rearm` after bit 0 reported, then toggling bit 0 -> second event 100.
